// File: rtl/mem_access_unit_pkg.sv
// mau_pkg: shared definitions for mem_access_unit.
//   - op-code values for the load/store request interface
//   - FSM state encoding (IDLE, ACCESS, MERGE, RESP)
//   - is_store / is_sub_word / is_misaligned helpers
package mau_pkg;

   localparam logic [2:0] OP_LB  = 3'b000;
   localparam logic [2:0] OP_LH  = 3'b001;
   localparam logic [2:0] OP_LW  = 3'b010;
   localparam logic [2:0] OP_SW  = 3'b011;
   localparam logic [2:0] OP_LBU = 3'b100;
   localparam logic [2:0] OP_LHU = 3'b101;
   localparam logic [2:0] OP_SB  = 3'b110;
   localparam logic [2:0] OP_SH  = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_MERGE  = 2'd2,
      ST_RESP   = 2'd3
   } state_t;

   function automatic logic is_store(input logic [2:0] op);
      return (op == OP_SW) || (op == OP_SB) || (op == OP_SH);
   endfunction

   // Byte or halfword access (anything but LW/SW).
   function automatic logic is_sub_word(input logic [2:0] op);
      return (op != OP_LW) && (op != OP_SW);
   endfunction

   function automatic logic is_misaligned(input logic [2:0] op, input logic [1:0] boff);
      logic half, word;
      half = (op == OP_LH) || (op == OP_LHU) || (op == OP_SH);
      word = (op == OP_LW) || (op == OP_SW);
      return (half && boff[0]) || (word && (boff != 2'b00));
   endfunction

endpackage

// File: rtl/mem_access_unit_byte_lane.sv
// byte_lane_unit: combinational lane select / merge for mem_access_unit.
// Ports:
//   op        in   request op code
//   boff      in   byte offset addr[1:0]
//   word      in   word currently held in memory
//   wdata     in   right-justified store data
//   load_val  out  selected byte/half/word, sign- or zero-extended
//   merged    out  word to write: old word with the selected lane replaced
//                  (SB/SH), or wdata unchanged for any other op
module byte_lane_unit
   import mau_pkg::*;
(
   input  logic [2:0]  op,
   input  logic [1:0]  boff,
   input  logic [31:0] word,
   input  logic [31:0] wdata,
   output logic [31:0] load_val,
   output logic [31:0] merged
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = 8'h00;
      case (boff)
         2'd0: byte_sel = word[7:0];
         2'd1: byte_sel = word[15:8];
         2'd2: byte_sel = word[23:16];
         2'd3: byte_sel = word[31:24];
         default: byte_sel = 8'h00;
      endcase
      // Halfword lane comes from addr[1] only; addr[0] is ignored here.
      half_sel = boff[1] ? word[31:16] : word[15:0];

      load_val = word;
      case (op)
         OP_LB:   load_val = {{24{byte_sel[7]}}, byte_sel};
         OP_LBU:  load_val = {24'h0, byte_sel};
         OP_LH:   load_val = {{16{half_sel[15]}}, half_sel};
         OP_LHU:  load_val = {16'h0, half_sel};
         default: load_val = word;
      endcase

      merged = wdata;
      if (op == OP_SB) begin
         merged = word;
         case (boff)
            2'd0: merged[7:0]   = wdata[7:0];
            2'd1: merged[15:8]  = wdata[7:0];
            2'd2: merged[23:16] = wdata[7:0];
            2'd3: merged[31:24] = wdata[7:0];
            default: merged = word;
         endcase
      end else if (op == OP_SH) begin
         merged = boff[1] ? {wdata[15:0], word[15:0]} : {word[31:16], wdata[15:0]};
      end
   end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store initiator for a word-addressed,
// combinational-read data memory. Sub-word stores are read-modify-write.
// Optional feature macro: MAU_ALIGN_CHECK_EN (alignment fault detection).
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_valid/req_ready      request handshake (ready only in IDLE)
//   req_op/addr/wdata        op code, byte address, right-justified store data
//   resp_valid               one-cycle completion pulse
//   resp_rdata               load result (0 for stores and faults)
//   resp_misalign            alignment fault, valid with resp_valid
//   mem_we/addr/wdata        to memory write port; mem_addr = {0, word index}
//   mem_rdata                combinational read data from memory
module mem_access_unit
   import mau_pkg::*;
#(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 32
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [2:0]        req_op,
   input  logic [31:0]       req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              resp_valid,
   output logic [DATA_W-1:0] resp_rdata,
   output logic              resp_misalign,
   output logic              mem_we,
   output logic [31:0]       mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   typedef struct packed {
      logic [2:0]        op;
      logic [1:0]        boff;
      logic [ADDR_W-1:0] widx;
      logic [DATA_W-1:0] wdata;
   } req_t;

   state_t            state;
   req_t              req_q;
   logic [DATA_W-1:0] load_val, merged;
   logic              fault;
   logic              misalign_q;
   // Address bits above the word index are ignored so accesses wrap.
   logic              unused_addr_hi;
   assign unused_addr_hi = ^req_addr[31:ADDR_W+2];

`ifdef MAU_ALIGN_CHECK_EN
   assign fault         = is_misaligned(req_op, req_addr[1:0]);
   assign resp_misalign = misalign_q;
`else
   assign fault         = 1'b0;
   assign resp_misalign = 1'b0;
`endif

   byte_lane_unit u_lane (
      .op       (req_q.op),
      .boff     (req_q.boff),
      .word     (mem_rdata),
      .wdata    (req_q.wdata),
      .load_val (load_val),
      .merged   (merged)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         req_q      <= '0;
         req_ready  <= 1'b1;
         resp_valid <= 1'b0;
         resp_rdata <= '0;
         misalign_q <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               // req_ready is registered high throughout IDLE.
               if (req_valid) begin
                  req_q     <= '{op: req_op, boff: req_addr[1:0],
                                 widx: req_addr[ADDR_W+1:2], wdata: req_wdata};
                  req_ready <= 1'b0;
                  if (fault) begin
                     state      <= ST_RESP;
                     resp_valid <= 1'b1;
                     resp_rdata <= '0;
                     misalign_q <= 1'b1;
                  end else begin
                     state     <= ST_ACCESS;
                     mem_addr  <= {{(32-ADDR_W){1'b0}}, req_addr[ADDR_W+1:2]};
                     // A full-word store writes on the ACCESS edge directly.
                     mem_we    <= (req_op == OP_SW);
                     mem_wdata <= req_wdata;
                  end
               end
            end
            ST_ACCESS: begin
               if (is_store(req_q.op) && is_sub_word(req_q.op)) begin
                  // Old word is on mem_rdata now; write the merged word next.
                  state     <= ST_MERGE;
                  mem_we    <= 1'b1;
                  mem_wdata <= merged;
               end else begin
                  state      <= ST_RESP;
                  mem_we     <= 1'b0;
                  mem_addr   <= '0;
                  resp_valid <= 1'b1;
                  resp_rdata <= is_store(req_q.op) ? '0 : load_val;
               end
            end
            ST_MERGE: begin
               state      <= ST_RESP;
               mem_we     <= 1'b0;
               mem_addr   <= '0;
               resp_valid <= 1'b1;
               resp_rdata <= '0;
            end
            ST_RESP: begin
               state      <= ST_IDLE;
               resp_valid <= 1'b0;
               misalign_q <= 1'b0;
               req_ready  <= 1'b1;
            end
            default: begin
               state     <= ST_IDLE;
               req_ready <= 1'b1;
               mem_we    <= 1'b0;
               mem_addr  <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: behavioural memory, directed scenarios and a
// randomized run checked against a reference model of the load/store rules.
module tb_mem_access_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready;
   logic [2:0]  req_op;
   logic [31:0] req_addr, req_wdata;
   logic        resp_valid, resp_misalign, mem_we;
   logic [31:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;

   logic [31:0] mem     [0:1023];
   logic [31:0] ref_mem [0:1023];

   int nvec = 0;
   int nerr = 0;

   always #5 clk = ~clk;

   assign mem_rdata = mem[mem_addr[9:0]];
   always @(posedge clk) if (mem_we) mem[mem_addr[9:0]] <= mem_wdata;

   mem_access_unit #(.ADDR_W(10), .DATA_W(32)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_misalign(resp_misalign),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   // Reference: expected result, fault flag, latency and write count of one
   // request; updates ref_mem for stores.
   task automatic ref_step(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wd,
                           output logic [31:0] rd, output logic mis, output int lat, output int nwr);
      int idx, k, j;
      logic [31:0] w, b, h;
      idx = int'(addr[11:2]);
      k   = int'(addr[1:0]);
      j   = int'(addr[1]);
      w   = ref_mem[idx];
      b   = (w >> (8*k)) & 32'hFF;
      h   = (w >> (16*j)) & 32'hFFFF;
      rd = 0; mis = 0; lat = 2; nwr = 0;
`ifdef MAU_ALIGN_CHECK_EN
      if (((op == 3'd1 || op == 3'd5 || op == 3'd7) && addr[0]) ||
          ((op == 3'd2 || op == 3'd3) && addr[1:0] != 2'd0)) begin
         mis = 1; lat = 1;
         return;
      end
`endif
      case (op)
         3'd0: rd = (b >= 128) ? b - 256 : b;
         3'd1: rd = (h >= 32768) ? h - 65536 : h;
         3'd2: rd = w;
         3'd4: rd = b;
         3'd5: rd = h;
         3'd3: begin ref_mem[idx] = wd; nwr = 1; end
         3'd6: begin
            ref_mem[idx] = (w & ~(32'hFF << (8*k))) | ((wd & 32'hFF) << (8*k));
            nwr = 1; lat = 3;
         end
         default: begin
            ref_mem[idx] = (w & ~(32'hFFFF << (16*j))) | ((wd & 32'hFFFF) << (16*j));
            nwr = 1; lat = 3;
         end
      endcase
   endtask

   // Issue one request from a negedge in IDLE and check the whole transaction.
   task automatic run_req(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wd,
                          output logic [31:0] rd);
      logic [31:0] e_rd;
      logic        e_mis;
      int          e_lat, e_nwr, nwr, wr_cyc, cyc;
      logic [9:0]  widx;
      bit          got;
      ref_step(op, addr, wd, e_rd, e_mis, e_lat, e_nwr);
      widx = addr[11:2];
      chk("ready_idle", req_ready, 1);
      req_valid = 1; req_op = op; req_addr = addr; req_wdata = wd;
      @(posedge clk); #1;
      // Fields must only matter at accept.
      req_valid = 0; req_op = 3'($urandom); req_addr = $urandom; req_wdata = $urandom;
      got = 0; nwr = 0; wr_cyc = 0; rd = 0;
      for (cyc = 1; cyc <= 6 && !got; cyc++) begin
         @(negedge clk);
         if (mem_we) begin
            nwr++; wr_cyc = cyc;
            chk("wr_addr", mem_addr, {22'h0, widx});
            chk("wr_data", mem_wdata, ref_mem[widx]);
         end
         if (resp_valid) begin
            got = 1;
            rd = resp_rdata;
            chk("latency", cyc, e_lat);
            chk("rdata", resp_rdata, e_rd);
            chk("misalign", resp_misalign, e_mis);
            chk("resp_addr0", mem_addr, 0);
            chk("resp_ready0", req_ready, 0);
         end
      end
      if (!got) chk("resp_timeout", 0, 1);
      chk("n_writes", nwr, e_nwr);
      if (e_nwr != 0) chk("write_cycle", wr_cyc, e_lat - 1);
      @(negedge clk);
      chk("resp_pulse", resp_valid, 0);
      chk("ready_back", req_ready, 1);
      chk("mem_word", mem[widx], ref_mem[widx]);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] rd;
      int pulses;
      for (int i = 0; i < 1024; i++) begin
         mem[i] = $urandom; ref_mem[i] = mem[i];
      end
      mem[33] = 32'h80FF7F01; ref_mem[33] = 32'h80FF7F01;
      mem[34] = 32'h11223344; ref_mem[34] = 32'h11223344;
      rst = 1; req_valid = 0; req_op = 0; req_addr = 0; req_wdata = 0;
      repeat (3) @(posedge clk);
      @(negedge clk); rst = 0;

      // Reset state and idle behaviour.
      chk("rst_rdata", resp_rdata, 0);
      chk("rst_misalign", resp_misalign, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      for (int i = 0; i < 4; i++) begin
         chk("idle_ready", req_ready, 1);
         chk("idle_we", mem_we, 0);
         chk("idle_resp", resp_valid, 0);
         @(negedge clk);
      end

      // Word store then load back.
      run_req(3'd3, 32'h80, 32'hDEADBEEF, rd);
      chk("sw_mem32", mem[32], 32'hDEADBEEF);
      run_req(3'd2, 32'h80, 32'h0, rd);
      chk("lw_80", rd, 32'hDEADBEEF);

      // Sub-word loads.
      run_req(3'd0, 32'h84, 0, rd); chk("lb_84", rd, 32'h00000001);
      run_req(3'd0, 32'h87, 0, rd); chk("lb_87", rd, 32'hFFFFFF80);
      run_req(3'd4, 32'h87, 0, rd); chk("lbu_87", rd, 32'h00000080);
      run_req(3'd1, 32'h86, 0, rd); chk("lh_86", rd, 32'hFFFF80FF);
      run_req(3'd5, 32'h86, 0, rd); chk("lhu_86", rd, 32'h000080FF);

      // Sub-word stores.
      run_req(3'd6, 32'h89, 32'hAA, rd);   chk("sb_89", mem[34], 32'h1122AA44);
      run_req(3'd7, 32'h8A, 32'hBEEF, rd); chk("sh_8a", mem[34], 32'hBEEFAA44);

      // Misaligned word load.
      run_req(3'd2, 32'h81, 0, rd);
`ifdef MAU_ALIGN_CHECK_EN
      chk("lw_81_fault", rd, 32'h0);
`else
      chk("lw_81", rd, 32'hDEADBEEF);
`endif

      // Reset during the ACCESS cycle of an SB: no write, no response.
      req_valid = 1; req_op = 3'd6; req_addr = 32'h88; req_wdata = 32'h55;
      @(posedge clk); #1; req_valid = 0;
      @(negedge clk); rst = 1;
      chk("abort_we_access", mem_we, 0);
      @(negedge clk); rst = 0;
      chk("abort_ready", req_ready, 1);
      chk("abort_resp", resp_valid, 0);
      chk("abort_we", mem_we, 0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("abort_quiet", {30'h0, resp_valid, mem_we}, 0);
      end
      chk("abort_mem34", mem[34], 32'hBEEFAA44);

      // Reset wins over a simultaneous request.
      rst = 1; req_valid = 1; req_op = 3'd3; req_addr = 32'h80; req_wdata = 32'h0;
      @(negedge clk); rst = 0; req_valid = 0;
      chk("rstreq_addr", mem_addr, 0);
      chk("rstreq_we", mem_we, 0);
      @(negedge clk);
      chk("rstreq_ready", req_ready, 1);
      chk("rstreq_mem32", mem[32], 32'hDEADBEEF);

      // req_valid held high: one accept per three cycles, only from IDLE.
      pulses = 0;
      req_valid = 1; req_op = 3'd2; req_addr = 32'h84;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         chk("held_we", mem_we, 0);
         if (resp_valid) begin
            pulses++;
            chk("held_rdata", resp_rdata, 32'h80FF7F01);
         end
      end
      req_valid = 0;
      chk("held_pulses", pulses, 4);
      chk("held_ready", req_ready, 1);

      // Randomized traffic over a few words, with wrapping high address bits.
      for (int n = 0; n < 200; n++) begin
         logic [31:0] a;
         a = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(40, 47)) << 2) | 32'($urandom_range(0, 3));
         run_req(3'($urandom_range(0, 7)), a, $urandom, rd);
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
